// File: rtl/seven_segment_decoder.sv
// Receive side of the 7-segment link: synchronises segment lines A..G, waits for a
// pattern to hold STABLE_CYCLES clocks, then commits and decodes it to a 4-bit value.
module seven_segment_decoder #(
    parameter int unsigned STABLE_CYCLES = 250000,
    parameter int unsigned CNT_WIDTH     = $clog2(STABLE_CYCLES)
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  logic       i_Segment_A,
    input  logic       i_Segment_B,
    input  logic       i_Segment_C,
    input  logic       i_Segment_D,
    input  logic       i_Segment_E,
    input  logic       i_Segment_F,
    input  logic       i_Segment_G,
    output logic [3:0] o_Binary_Num,
    output logic       o_Valid,
    output logic       o_Stable,
    output logic       o_Blank,
    output logic       o_Error,
    output logic       o_Unknown,
    output logic [7:0] o_Unknown_Count
);

    localparam int unsigned PAT_W = 7;
    localparam int unsigned NUM_W = 4;
    localparam int unsigned UCNT_W = 8;

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);
    localparam logic [UCNT_W-1:0]    UCNT_MAX = '1;

    localparam logic [PAT_W-1:0] PAT_0     = 7'b1111110;
    localparam logic [PAT_W-1:0] PAT_1     = 7'b0110000;
    localparam logic [PAT_W-1:0] PAT_2     = 7'b1101101;
    localparam logic [PAT_W-1:0] PAT_3     = 7'b1111001;
    localparam logic [PAT_W-1:0] PAT_4     = 7'b0110011;
    localparam logic [PAT_W-1:0] PAT_5     = 7'b1011011;
    localparam logic [PAT_W-1:0] PAT_6     = 7'b1011111;
    localparam logic [PAT_W-1:0] PAT_7     = 7'b1110000;
    localparam logic [PAT_W-1:0] PAT_8     = 7'b1111111;
    localparam logic [PAT_W-1:0] PAT_9     = 7'b1111011;
    localparam logic [PAT_W-1:0] PAT_E     = 7'b1001111;
    localparam logic [PAT_W-1:0] PAT_BLANK = 7'b0000000;

    typedef enum logic {
        SETTLING = 1'b0,
        LOCKED   = 1'b1
    } state_e;

    logic [PAT_W-1:0]     pattern;
    logic [PAT_W-1:0]     sync1_q, sync2_q;
    logic [PAT_W-1:0]     cand_q, cand_d;
    logic [PAT_W-1:0]     last_q, last_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    state_e               state_q, state_d;
    logic                 committed_q, committed_d;
    logic [NUM_W-1:0]     num_q, num_d;
    logic                 valid_q, valid_d;
    logic                 stable_q, stable_d;
    logic                 blank_q, blank_d;
    logic                 error_q, error_d;
    logic                 unknown_q, unknown_d;
    logic [UCNT_W-1:0]    ucnt_q, ucnt_d;

    logic [NUM_W-1:0]     dec_num;
    logic                 dec_blank, dec_error, dec_unknown;

    assign pattern = {i_Segment_A, i_Segment_B, i_Segment_C, i_Segment_D,
                      i_Segment_E, i_Segment_F, i_Segment_G};

    // Two-flop synchroniser per segment line
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= pattern;
            sync2_q <= sync1_q;
        end
    end

    // Pattern-to-value decode of the current candidate
    always_comb begin
        dec_num     = 4'hF;
        dec_blank   = 1'b0;
        dec_error   = 1'b0;
        dec_unknown = 1'b0;
        unique case (cand_q)
            PAT_0:     dec_num = 4'd0;
            PAT_1:     dec_num = 4'd1;
            PAT_2:     dec_num = 4'd2;
            PAT_3:     dec_num = 4'd3;
            PAT_4:     dec_num = 4'd4;
            PAT_5:     dec_num = 4'd5;
            PAT_6:     dec_num = 4'd6;
            PAT_7:     dec_num = 4'd7;
            PAT_8:     dec_num = 4'd8;
            PAT_9:     dec_num = 4'd9;
            PAT_E: begin
                dec_num   = 4'hE;
                dec_error = 1'b1;
            end
            PAT_BLANK: dec_blank = 1'b1;
            default:   dec_unknown = 1'b1;
        endcase
    end

    // Stability tracking and commit; a commit of the already-committed pattern is silent
    always_comb begin
        cand_d      = cand_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        state_d     = state_q;
        committed_d = committed_q;
        num_d       = num_q;
        valid_d     = 1'b0;
        stable_d    = stable_q;
        blank_d     = blank_q;
        error_d     = error_q;
        unknown_d   = unknown_q;
        ucnt_d      = ucnt_q;

        if (sync2_q != cand_q) begin
            cand_d   = sync2_q;
            cnt_d    = '0;
            state_d  = SETTLING;
            stable_d = 1'b0;
        end else if (state_q == SETTLING) begin
            if (cnt_q == CNT_LAST) begin
                state_d  = LOCKED;
                stable_d = 1'b1;
                if (!committed_q || (cand_q != last_q)) begin
                    committed_d = 1'b1;
                    last_d      = cand_q;
                    num_d       = dec_num;
                    blank_d     = dec_blank;
                    error_d     = dec_error;
                    unknown_d   = dec_unknown;
                    valid_d     = 1'b1;
                    if (dec_unknown && (ucnt_q != UCNT_MAX)) begin
                        ucnt_d = ucnt_q + UCNT_W'(1);
                    end
                end
            end else begin
                cnt_d = cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            cand_q      <= '0;
            last_q      <= '0;
            cnt_q       <= '0;
            state_q     <= SETTLING;
            committed_q <= 1'b0;
            num_q       <= 4'hF;
            valid_q     <= 1'b0;
            stable_q    <= 1'b0;
            blank_q     <= 1'b0;
            error_q     <= 1'b0;
            unknown_q   <= 1'b0;
            ucnt_q      <= '0;
        end else begin
            cand_q      <= cand_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            state_q     <= state_d;
            committed_q <= committed_d;
            num_q       <= num_d;
            valid_q     <= valid_d;
            stable_q    <= stable_d;
            blank_q     <= blank_d;
            error_q     <= error_d;
            unknown_q   <= unknown_d;
            ucnt_q      <= ucnt_d;
        end
    end

    assign o_Binary_Num    = num_q;
    assign o_Valid         = valid_q;
    assign o_Stable        = stable_q;
    assign o_Blank         = blank_q;
    assign o_Error         = error_q;
    assign o_Unknown       = unknown_q;
    assign o_Unknown_Count = ucnt_q;

endmodule

// File: tb/tb_seven_segment_decoder.sv
// Self-checking bench for seven_segment_decoder: directed and random segment patterns
// compared each cycle against a run-length reference model of the receiver.
module tb_seven_segment_decoder;

    localparam int unsigned SC = 4;

    logic       clk;
    logic       rst_n;
    logic [6:0] pat;
    logic [3:0] o_num;
    logic       o_valid, o_stable, o_blank, o_error, o_unknown;
    logic [7:0] o_ucnt;

    seven_segment_decoder #(.STABLE_CYCLES(SC)) dut (
        .i_Clk          (clk),
        .i_Rst_L        (rst_n),
        .i_Segment_A    (pat[6]),
        .i_Segment_B    (pat[5]),
        .i_Segment_C    (pat[4]),
        .i_Segment_D    (pat[3]),
        .i_Segment_E    (pat[2]),
        .i_Segment_F    (pat[1]),
        .i_Segment_G    (pat[0]),
        .o_Binary_Num   (o_num),
        .o_Valid        (o_valid),
        .o_Stable       (o_stable),
        .o_Blank        (o_blank),
        .o_Error        (o_error),
        .o_Unknown      (o_unknown),
        .o_Unknown_Count(o_ucnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [6:0] digit_tab [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                                   7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};

    // Reference model state: S is the input seen two edges earlier; a pattern commits
    // on the edge where it has been seen for SC+1 consecutive edges.
    logic [6:0] h1, h2, prev_s, last_pat;
    int         run;
    bit         committed;
    logic [3:0] e_num;
    logic       e_valid, e_stable, e_blank, e_error, e_unknown;
    int         e_ucnt;
    int         n_valid;

    function automatic void decode(input logic [6:0] p, output logic [3:0] num,
                                   output logic blank, output logic err, output logic unk);
        num = 4'hF; blank = 0; err = 0; unk = 1;
        for (int d = 0; d < 10; d++) if (digit_tab[d] == p) begin num = 4'(d); unk = 0; end
        if (p == 7'b1001111) begin num = 4'hE; err = 1; unk = 0; end
        if (p == 7'b0000000) begin blank = 1; unk = 0; end
    endfunction

    function automatic bit is_defined(input logic [6:0] p);
        logic [3:0] n; logic b, e, u;
        decode(p, n, b, e, u);
        return !u;
    endfunction

    task automatic model_reset();
        h1 = '0; h2 = '0; prev_s = '0; last_pat = '0;
        run = 1; committed = 0;
        e_num = 4'hF; e_valid = 0; e_stable = 0; e_blank = 0; e_error = 0; e_unknown = 0;
        e_ucnt = 0;
    endtask

    task automatic model_edge();
        logic [6:0] s;
        s = h2; h2 = h1; h1 = pat;
        if (s == prev_s) begin
            if (run < 1000) run++;
        end else begin
            run = 1;
        end
        prev_s  = s;
        e_valid = 0;
        e_stable = (run > SC);
        if (run == SC + 1 && (!committed || s != last_pat)) begin
            committed = 1;
            last_pat  = s;
            decode(s, e_num, e_blank, e_error, e_unknown);
            e_valid = 1;
            if (e_unknown && e_ucnt < 255) e_ucnt++;
        end
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("num", int'(o_num), int'(e_num));
        check("valid", int'(o_valid), int'(e_valid));
        check("stable", int'(o_stable), int'(e_stable));
        check("blank", int'(o_blank), int'(e_blank));
        check("error", int'(o_error), int'(e_error));
        check("unknown", int'(o_unknown), int'(e_unknown));
        check("ucnt", int'(o_ucnt), e_ucnt);
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            if (rst_n) model_edge();
            #1;
            if (o_valid === 1'b1) n_valid++;
            check_all();
        end
    endtask

    function automatic logic [6:0] rand_unknown();
        logic [6:0] p;
        p = 7'(($urandom));
        for (int k = 0; k < 200 && is_defined(p); k++) p = 7'($urandom);
        if (is_defined(p)) p = 7'b0101010;
        return p;
    endfunction

    initial begin
        int first_valid_edge;
        logic [6:0] tmp;

        rst_n = 1'b1;
        pat   = '0;
        model_reset();
        #2 rst_n = 1'b0;
        #1 check_all();
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Blank commit after reset
        first_valid_edge = 0;
        for (int e = 1; e <= 7 && first_valid_edge == 0; e++) begin
            step(1);
            if (o_valid === 1'b1) first_valid_edge = e;
        end
        check("reset_blank_commit_seen", int'(first_valid_edge != 0), 1);
        check("reset_blank_flag", int'(o_blank), 1);
        check("reset_blank_num", int'(o_num), 15);
        step(5);
        check("reset_blank_stable", int'(o_stable), 1);

        // Steady digit 3: exactly one pulse, on edge SC+3
        pat = 7'b1111001;
        n_valid = 0;
        step(SC + 2);
        check("digit3_not_yet", int'(o_valid), 0);
        step(1);
        check("digit3_latency", int'(o_valid), 1);
        check("digit3_num", int'(o_num), 3);
        step(50);
        check("digit3_single_pulse", n_valid, 1);

        // Glitch to 8 for two cycles while locked
        n_valid = 0;
        pat = 7'b1111111;
        step(2);
        pat = 7'b1111001;
        step(2);
        check("glitch_stable_low", int'(o_stable), 0);
        check("glitch_num_holds", int'(o_num), 3);
        step(20);
        check("glitch_stable_back", int'(o_stable), 1);
        check("glitch_no_pulse", n_valid, 0);

        // Digit sweep
        n_valid = 0;
        for (int d = 0; d < 10; d++) begin
            tmp = digit_tab[d];
            pat = tmp;
            step(10);
            check("sweep_value", int'(o_num), d);
        end
        check("sweep_pulses", n_valid, 10);

        // Remote error then unknown
        pat = 7'b1001111;
        step(12);
        check("e_flag", int'(o_error), 1);
        check("e_num", int'(o_num), 14);
        pat = 7'b0101010;
        step(12);
        check("unk_flag", int'(o_unknown), 1);
        check("unk_num", int'(o_num), 15);
        check("unk_count1", int'(o_ucnt), 1);

        // Saturation of the unknown counter
        for (int r = 0; r < 300; r++) begin
            pat = digit_tab[$urandom_range(9)];
            step(8);
            pat = rand_unknown();
            step(8);
        end
        check("unk_saturated", int'(o_ucnt), 255);

        // Random patterns with random hold times, including toggling shorter than SC
        for (int r = 0; r < 300; r++) begin
            case ($urandom_range(3))
                0: pat = digit_tab[$urandom_range(9)];
                1: pat = rand_unknown();
                2: pat = 7'b1001111;
                default: pat = 7'($urandom);
            endcase
            step($urandom_range(1, 9));
        end

        // Continuous toggling never commits
        pat = 7'b0110000;
        step(12);
        n_valid = 0;
        for (int r = 0; r < 20; r++) begin
            pat = (r % 2 == 0) ? 7'b1011011 : 7'b1110000;
            step(1);
        end
        check("toggle_no_pulse", n_valid, 0);
        check("toggle_num_holds", int'(o_num), 1);

        // Reset mid-settle, then re-commit of the same pattern must pulse
        pat = 7'b1011011;
        step(12);
        pat = 7'b1110000;
        step(1);
        pat = 7'b1011011;
        for (int k = 0; k < 20 && run != 3; k++) step(1);
        check("midsettle_reached", run, 3);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        step(2);
        #1 rst_n = 1'b1;
        n_valid = 0;
        step(15);
        check("post_reset_pulse", n_valid, 1);
        check("post_reset_num", int'(o_num), 5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
